mem_access_unit: RTL and testbench

//  MEM-stage consumer of the EXE/MEM pipeline register outputs. Performs data-memory

---
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage consumer of the EXE/MEM pipeline register. Memory ops (stores, and
// loads marked by in_wsrc == WSRC_MEM) are issued to a variable-latency data
// memory over a req/ack handshake. Upstream is stalled while an access is
// outstanding. Non-memory ops pass through with one cycle of latency.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that sees no
// mem_ack within TIMEOUT_CYCLES busy cycles. The aborted op completes with
// out_err=1 and out_regwe=0. Without the macro, BUSY waits indefinitely and
// out_err is tied to 0.
//
// Ports
//   clk, rst                      clock; synchronous active-low reset
//   in_valid/in_we/in_wsrc        op present, store enable, write-back source
//   in_alures/in_wdata            ALU result (also byte address), store data
//   in_wreg/in_regwe              destination register and its write enable
//   stall                         upstream must hold its register while 1
//   mem_req/mem_we/mem_addr/
//   mem_wdata                     memory request, held stable while busy
//   mem_ack/mem_rdata             completion strobe and read data
//   out_valid                     one-cycle pulse: out_* fields are valid
//   out_rdata/out_alures/out_wreg/
//   out_regwe/out_wsrc/out_err    registered results for MEM/WB
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int                 WSRC_W         = 2,
    parameter logic [WSRC_W-1:0]  WSRC_MEM       = WSRC_W'(1),
    parameter int                 TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_we,
    input  logic [WSRC_W-1:0] in_wsrc,
    input  logic [31:0]       in_alures,
    input  logic [31:0]       in_wdata,
    input  logic [4:0]        in_wreg,
    input  logic              in_regwe,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic [31:0]       out_rdata,
    output logic [31:0]       out_alures,
    output logic [4:0]        out_wreg,
    output logic              out_regwe,
    output logic [WSRC_W-1:0] out_wsrc,
    output logic              out_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]        state_q,      state_d;
    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [31:0]       mem_addr_q,   mem_addr_d;
    logic [31:0]       mem_wdata_q,  mem_wdata_d;
    logic              out_valid_q,  out_valid_d;
    logic [31:0]       out_rdata_q,  out_rdata_d;
    logic [31:0]       out_alures_q, out_alures_d;
    logic [4:0]        out_wreg_q,   out_wreg_d;
    logic              out_regwe_q,  out_regwe_d;
    logic [WSRC_W-1:0] out_wsrc_q,   out_wsrc_d;
    logic              is_mem_op;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              out_err_q,    out_err_d;
`endif

    // Store wins over load when both in_we and the load source are set.
    assign is_mem_op = in_we || (in_wsrc == WSRC_MEM);

    always_comb begin
        // NOTE: every _d gets a default (hold) first, so no path leaves a
        // signal unassigned and no latch is inferred.
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        out_valid_d  = 1'b0;
        out_rdata_d  = out_rdata_q;
        out_alures_d = out_alures_q;
        out_wreg_d   = out_wreg_q;
        out_regwe_d  = out_regwe_q;
        out_wsrc_d   = out_wsrc_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
        out_err_d    = out_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                // mem_ack is deliberately not looked at here: stray acks are dropped.
                if (in_valid) begin
                    out_alures_d = in_alures;
                    out_wreg_d   = in_wreg;
                    out_regwe_d  = in_regwe;
                    out_wsrc_d   = in_wsrc;
                    if (is_mem_op) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_we;
                        mem_addr_d  = in_alures;
                        mem_wdata_d = in_wdata;
                        state_d     = S_BUSY;
`ifdef MEM_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        out_valid_d = 1'b1;
                        out_rdata_d = 32'h0;
`ifdef MEM_TIMEOUT_EN
                        out_err_d   = 1'b0;
`endif
                    end
                end
            end
            default: begin  // S_BUSY: request fields stay put, in_* ignored
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    out_rdata_d = mem_we_q ? 32'h0 : mem_rdata;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
`ifdef MEM_TIMEOUT_EN
                    out_err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // cnt_q counts completed busy cycles, so this is the
                    // TIMEOUT_CYCLES-th cycle with mem_req high and no ack.
                    mem_req_d   = 1'b0;
                    out_rdata_d = 32'h0;
                    out_regwe_d = 1'b0;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            out_valid_q  <= 1'b0;
            out_rdata_q  <= 32'h0;
            out_alures_q <= 32'h0;
            out_wreg_q   <= 5'h0;
            out_regwe_q  <= 1'b0;
            out_wsrc_q   <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
            out_err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its _d, independent of statement order.
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            out_valid_q  <= out_valid_d;
            out_rdata_q  <= out_rdata_d;
            out_alures_q <= out_alures_d;
            out_wreg_q   <= out_wreg_d;
            out_regwe_q  <= out_regwe_d;
            out_wsrc_q   <= out_wsrc_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
            out_err_q    <= out_err_d;
`endif
        end
    end

    // stall comes straight from the state flop, never from inputs.
    assign stall      = (state_q == S_BUSY);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign out_valid  = out_valid_q;
    assign out_rdata  = out_rdata_q;
    assign out_alures = out_alures_q;
    assign out_wreg   = out_wreg_q;
    assign out_regwe  = out_regwe_q;
    assign out_wsrc   = out_wsrc_q;
`ifdef MEM_TIMEOUT_EN
    assign out_err    = out_err_q;
`else
    assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. Ops are described as transactions
// (op fields, ack delay, read data); the expected outputs of each transaction
// are computed from the handshake rules and compared cycle by cycle.
// Define MEM_TIMEOUT_EN to also exercise the timeout abort (TIMEOUT_CYCLES=4).
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int          WSRC_W   = 2;
    localparam logic [1:0]  WSRC_MEM = 2'b01;
`ifdef MEM_TIMEOUT_EN
    localparam int          TIMEOUT  = 4;
    localparam int          MAX_DLY  = TIMEOUT - 1;
`else
    localparam int          TIMEOUT  = 255;
    localparam int          MAX_DLY  = 6;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_we, in_regwe;
    logic [1:0]        in_wsrc;
    logic [31:0]       in_alures, in_wdata;
    logic [4:0]        in_wreg;
    logic              stall, mem_req, mem_we;
    logic [31:0]       mem_addr, mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              out_valid, out_regwe, out_err;
    logic [31:0]       out_rdata, out_alures;
    logic [4:0]        out_wreg;
    logic [1:0]        out_wsrc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] alures;
        logic [31:0] rdata;
        logic [4:0]  wreg;
        logic        regwe;
        logic [1:0]  wsrc;
        logic        err;
    } result_t;

    result_t last_res;

    mem_access_unit #(
        .WSRC_W        (WSRC_W),
        .WSRC_MEM      (WSRC_MEM),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_we     (in_we),
        .in_wsrc   (in_wsrc),
        .in_alures (in_alures),
        .in_wdata  (in_wdata),
        .in_wreg   (in_wreg),
        .in_regwe  (in_regwe),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_rdata (out_rdata),
        .out_alures(out_alures),
        .out_wreg  (out_wreg),
        .out_regwe (out_regwe),
        .out_wsrc  (out_wsrc),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_garbage(input logic valid);
        in_valid  = valid;
        in_we     = 1'($urandom);
        in_wsrc   = 2'($urandom);
        in_alures = $urandom;
        in_wdata  = $urandom;
        in_wreg   = 5'($urandom);
        in_regwe  = 1'($urandom);
    endtask

    task automatic check_result(input string tag, input result_t r);
        check({tag, ".out_valid"},  out_valid,  1);
        check({tag, ".out_alures"}, out_alures, r.alures);
        check({tag, ".out_rdata"},  out_rdata,  r.rdata);
        check({tag, ".out_wreg"},   out_wreg,   r.wreg);
        check({tag, ".out_regwe"},  out_regwe,  r.regwe);
        check({tag, ".out_wsrc"},   out_wsrc,   r.wsrc);
        check({tag, ".out_err"},    out_err,    r.err);
        check({tag, ".mem_req"},    mem_req,    0);
        check({tag, ".stall"},      stall,      0);
    endtask

    // One complete transaction. dly = cycles between mem_req rising and mem_ack.
    task automatic run_op(input string tag, input logic we, input logic [1:0] wsrc,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] wreg, input logic regwe,
                          input int dly, input logic [31:0] rd);
        logic    is_mem;
        result_t exp;
        is_mem     = we || (wsrc == WSRC_MEM);
        exp.alures = addr;
        exp.wreg   = wreg;
        exp.regwe  = regwe;
        exp.wsrc   = wsrc;
        exp.err    = 1'b0;
        exp.rdata  = (is_mem && !we) ? rd : 32'h0;

        check({tag, ".accept_stall"}, stall, 0);
        in_valid  = 1'b1;
        in_we     = we;
        in_wsrc   = wsrc;
        in_alures = addr;
        in_wdata  = wd;
        in_wreg   = wreg;
        in_regwe  = regwe;
        tick();
        if (is_mem) begin
            drive_garbage(1'($urandom));  // must be ignored while busy
            for (int k = 0; k <= dly; k++) begin
                check({tag, ".busy_req"},   mem_req,   1);
                check({tag, ".busy_stall"}, stall,     1);
                check({tag, ".busy_we"},    mem_we,    we);
                check({tag, ".busy_addr"},  mem_addr,  addr);
                check({tag, ".busy_wdata"}, mem_wdata, wd);
                check({tag, ".busy_valid"}, out_valid, 0);
                mem_ack   = (k == dly);
                mem_rdata = (k == dly) ? rd : $urandom;
                tick();
                drive_garbage(1'($urandom));
            end
            mem_ack = 1'b0;
        end
        in_valid = 1'b0;
        check_result(tag, exp);
        last_res = exp;
    endtask

    initial begin
        rst       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        drive_garbage(1'b0);
        last_res  = '{default: '0};

        // Reset with random activity on the inputs.
        for (int i = 0; i < 2; i++) begin
            drive_garbage(1'b1);
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            tick();
        end
        check("rst.stall",      stall,      0);
        check("rst.mem_req",    mem_req,    0);
        check("rst.mem_we",     mem_we,     0);
        check("rst.mem_addr",   mem_addr,   0);
        check("rst.mem_wdata",  mem_wdata,  0);
        check("rst.out_valid",  out_valid,  0);
        check("rst.out_rdata",  out_rdata,  0);
        check("rst.out_alures", out_alures, 0);
        check("rst.out_wreg",   out_wreg,   0);
        check("rst.out_regwe",  out_regwe,  0);
        check("rst.out_wsrc",   out_wsrc,   0);
        check("rst.out_err",    out_err,    0);
        rst      = 1'b1;
        in_valid = 1'b0;
        mem_ack  = 1'b0;
        tick();

        // Directed: ALU op, load with 2-cycle ack, store with 0-cycle ack.
        run_op("alu",   1'b0, 2'b00, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
        run_op("load",  1'b0, 2'b01, 32'h100,  32'h55, 5'd7, 1'b1, 2, 32'hDEADBEEF);
        run_op("store", 1'b1, 2'b00, 32'h200,  32'hCAFEF00D, 5'd0, 1'b0, 0, 32'h12345678);
        // Store priority when in_we and the load source are both set.
        run_op("st_prio", 1'b1, 2'b01, 32'h300, 32'hA5A5A5A5, 5'd9, 1'b1, 1, 32'hFFFF0000);
        // Back-to-back loads: second accepted right in the completion cycle.
        run_op("b2b_0", 1'b0, 2'b01, 32'h400, 32'h0, 5'd1, 1'b1, 0, 32'h11111111);
        run_op("b2b_1", 1'b0, 2'b01, 32'h404, 32'h0, 5'd2, 1'b1, 0, 32'h22222222);

        // Idle cycle: out_valid drops, fields hold.
        drive_garbage(1'b0);
        tick();
        check("idle.out_valid",  out_valid,  0);
        check("idle.out_alures", out_alures, last_res.alures);
        check("idle.out_wreg",   out_wreg,   last_res.wreg);
        check("idle.out_rdata",  out_rdata,  last_res.rdata);

        // Stray ack while idle is ignored.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray.mem_req",   mem_req,   0);
        check("stray.stall",     stall,     0);
        check("stray.out_valid", out_valid, 0);

        // Reset in the middle of a load.
        in_valid  = 1'b1;
        in_we     = 1'b0;
        in_wsrc   = WSRC_MEM;
        in_alures = 32'h500;
        in_regwe  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rstbusy.req_up", mem_req, 1);
        tick();
        rst = 1'b0;
        tick();
        check("rstbusy.mem_req",   mem_req,   0);
        check("rstbusy.stall",     stall,     0);
        check("rstbusy.out_valid", out_valid, 0);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_ack = 1'b0;
        check("rstbusy.no_valid", out_valid, 0);
        check("rstbusy.no_req",   mem_req,   0);
        run_op("after_rst", 1'b0, 2'b10, 32'hABCD, 32'h0, 5'd3, 1'b1, 0, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // Load that never gets an ack.
        begin
            int req_cycles;
            in_valid  = 1'b1;
            in_we     = 1'b0;
            in_wsrc   = WSRC_MEM;
            in_alures = 32'h600;
            in_wreg   = 5'd4;
            in_regwe  = 1'b1;
            tick();
            in_valid   = 1'b0;
            req_cycles = 0;
            while (mem_req && req_cycles < 20) begin
                req_cycles++;
                tick();
            end
            check("tmo.req_cycles", req_cycles, TIMEOUT);
            check("tmo.out_valid",  out_valid,  1);
            check("tmo.out_err",    out_err,    1);
            check("tmo.out_regwe",  out_regwe,  0);
            check("tmo.out_rdata",  out_rdata,  0);
            check("tmo.out_alures", out_alures, 32'h600);
            mem_ack   = 1'b1;
            mem_rdata = 32'h77777777;
            tick();
            mem_ack = 1'b0;
            check("tmo.late_valid", out_valid, 0);
            check("tmo.late_req",   mem_req,   0);
            check("tmo.err_hold",   out_err,   1);
            run_op("tmo_clear", 1'b0, 2'b00, 32'h9, 32'h0, 5'd6, 1'b1, 0, 32'h0);
        end
`endif

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [1:0]  wsrc;
            we   = ($urandom_range(0, 3) == 0);
            wsrc = 2'($urandom);
            run_op($sformatf("rnd%0d", i), we, wsrc, $urandom, $urandom, 5'($urandom),
                   1'($urandom), int'($urandom_range(0, MAX_DLY)), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                drive_garbage(1'b0);
                tick();
                check("rnd.gap_valid",  out_valid,  0);
                check("rnd.gap_alures", out_alures, last_res.alures);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
